// File: rtl/shi_reg_ctrl.sv
// Sequencer for a WORDS-deep shift chain: clears it, fills it from an upstream stream,
// then drains it in FIFO order to a downstream stream with zero backfill.
module shi_reg_ctrl #(
  parameter int unsigned WORDS = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         out_data_o,
  output logic                     out_last_o,
  output logic                     sr_we_o,
  output logic [WIDTH-1:0]         sr_din_o,
  input  logic [WIDTH-1:0]         sr_dout_i,
  output logic [$clog2(WORDS):0]   count_o
);

  localparam int unsigned CntW = $clog2(WORDS);
  localparam logic [CntW-1:0] LastIdx = CntW'(WORDS - 1);

  typedef enum logic [1:0] {StClear, StFill, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW:0]   count_q, count_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StClear;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    sr_we_o     = 1'b0;
    sr_din_o    = '0;

    if (flush_i) begin
      // Abort suppresses every handshake this cycle and restarts the clear sweep.
      state_d = StClear;
      cnt_d   = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        StClear: begin
          sr_we_o = 1'b1;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == LastIdx) begin
            state_d = StFill;
            cnt_d   = '0;
          end
        end
        StFill: begin
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            sr_we_o  = 1'b1;
            sr_din_o = in_data_i;
            cnt_d    = cnt_q + CntW'(1);
            count_d  = count_q + (CntW + 1)'(1);
            if (cnt_q == LastIdx) begin
              state_d = StDrain;
              cnt_d   = '0;
            end
          end
        end
        StDrain: begin
          out_valid_o = 1'b1;
          out_last_o  = (cnt_q == LastIdx);
          if (out_ready_i) begin
            sr_we_o = 1'b1;
            cnt_d   = cnt_q + CntW'(1);
            count_d = count_q - (CntW + 1)'(1);
            if (cnt_q == LastIdx) begin
              state_d = StFill;
              cnt_d   = '0;
              count_d = '0;
            end
          end
        end
        default: begin
          state_d = StClear;
          cnt_d   = '0;
          count_d = '0;
        end
      endcase
    end
  end

  assign out_data_o = sr_dout_i;
  assign count_o    = count_q;

endmodule
